int_arbiter: RTL and testbench

//  Interrupt controller between the bridge's device IRQ lines and the CP0 hwint[5:0] input.
//  - Latches device requests and applies a per-source mask and edge/level mode.
//  - Selects one winner and presents it one-hot on hwint.
//  - Holds the winner through acknowledge (exlset) and service completion (eret/exlclr).
//  - Registers are read and written over the bridge word bus.

---
 rtl/int_arbiter.sv | 144 ++++++++++++++
 tb/tb_int_arbiter.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/int_arbiter.sv
// int_arbiter: latches device IRQs, applies mask/edge mode, presents one winner one-hot on hwint until eret.
// Define INT_PRIO_ROTATE_EN for round-robin selection; otherwise the lowest eligible index wins.
module int_arbiter #(
  parameter int N_SRC = 6,
  parameter int ID_W  = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] dev_irq,
  input  logic             we,
  input  logic [1:0]       addr,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata,
  input  logic             int_ack,
  input  logic             int_done,
  output logic [N_SRC-1:0] hwint,
  output logic [ID_W-1:0]  cur_id,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    SVC  = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [N_SRC-1:0] dev_q, pend, pend_nxt, edge_mode, mask, elig;
  logic [ID_W-1:0]  cur_id_nxt, sel_id;
  logic             sel_vld;
  logic             wr_pend, wr_edge, wr_mask, take;
  logic             unused_wdata;

  assign wr_pend      = we && (addr == 2'd0);
  assign wr_edge      = we && (addr == 2'd1);
  assign wr_mask      = we && (addr == 2'd2);
  assign elig         = pend & mask;
  assign take         = (state == REQ) && int_ack;
  assign busy         = (state == REQ) || (state == SVC);
  assign unused_wdata = ^wdata[31:N_SRC];

  // Level sources track the line directly; for edge sources a new edge beats a same-cycle clear.
  always_comb begin
    pend_nxt = pend;
    for (int i = 0; i < N_SRC; i++) begin
      if (!edge_mode[i])
        pend_nxt[i] = dev_irq[i];
      else if (dev_irq[i] && !dev_q[i])
        pend_nxt[i] = 1'b1;
      else if ((wr_pend && wdata[i]) || (take && (cur_id == ID_W'(i))))
        pend_nxt[i] = 1'b0;
    end
  end

`ifdef INT_PRIO_ROTATE_EN
  logic [ID_W-1:0] last_id, start_id;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      last_id <= ID_W'(N_SRC - 1);
    else if (take)
      last_id <= cur_id;
  end

  assign start_id = (last_id >= ID_W'(N_SRC - 1)) ? '0 : last_id + 1'b1;

  // Lowest index at or above start_id; if none, wrap to the lowest eligible index.
  always_comb begin
    sel_vld = |elig;
    sel_id  = '0;
    for (int i = N_SRC - 1; i >= 0; i--)
      if (elig[i]) sel_id = ID_W'(i);
    for (int i = N_SRC - 1; i >= 0; i--)
      if (elig[i] && (ID_W'(i) >= start_id)) sel_id = ID_W'(i);
  end
`else
  always_comb begin
    sel_vld = |elig;
    sel_id  = '0;
    for (int i = N_SRC - 1; i >= 0; i--)
      if (elig[i]) sel_id = ID_W'(i);
  end
`endif

  always_comb begin
    state_nxt  = state;
    cur_id_nxt = cur_id;
    hwint      = '0;
    case (state)
      IDLE: begin
        if (sel_vld) begin
          state_nxt  = REQ;
          cur_id_nxt = sel_id;
        end
      end
      REQ: begin
        hwint = N_SRC'(1) << cur_id;
        if (int_ack)
          state_nxt = SVC;
        else if (!elig[cur_id])
          state_nxt = IDLE;
      end
      SVC: begin
        hwint = N_SRC'(1) << cur_id;
        if (int_done)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dev_q     <= '0;
      pend      <= '0;
      edge_mode <= '0;
      mask      <= '0;
      state     <= IDLE;
      cur_id    <= '0;
    end else begin
      dev_q  <= dev_irq;
      pend   <= pend_nxt;
      state  <= state_nxt;
      cur_id <= cur_id_nxt;
      if (wr_edge) edge_mode <= wdata[N_SRC-1:0];
      if (wr_mask) mask      <= wdata[N_SRC-1:0];
    end
  end

  always_comb begin
    rdata = '0;
    case (addr)
      2'd0: rdata[N_SRC-1:0] = pend;
      2'd1: rdata[N_SRC-1:0] = edge_mode;
      2'd2: rdata[N_SRC-1:0] = mask;
      default: begin
        rdata[31]              = busy;
        rdata[ID_W+6:ID_W+5]   = state;
        rdata[ID_W-1:0]        = cur_id;
      end
    endcase
  end

endmodule

// File: tb/tb_int_arbiter.sv
// Self-checking bench for int_arbiter: vector table through a scoreboard queue, plus reset and rotation sequences.
module tb_int_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  dev_irq;
  logic        we;
  logic [1:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        int_ack;
  logic        int_done;
  logic [5:0]  hwint;
  logic [2:0]  cur_id;
  logic        busy;

  int n_chk  = 0;
  int n_pass = 0;

  int_arbiter #(.N_SRC(6), .ID_W(3)) dut (
    .clk      (clk),
    .reset    (reset),
    .dev_irq  (dev_irq),
    .we       (we),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .int_ack  (int_ack),
    .int_done (int_done),
    .hwint    (hwint),
    .cur_id   (cur_id),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  dev;
    logic        we;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic        ack;
    logic        done;
    logic [1:0]  raddr;
    logic [5:0]  e_hwint;
    logic        e_busy;
    logic [31:0] e_rdata;
  } vec_t;

  vec_t tbl [36];
  vec_t sb [$];
  int   id_q [$];

  function automatic vec_t mk(input logic [5:0] dv, input logic w, input logic [1:0] a,
                              input logic [31:0] wd, input logic ak, input logic dn,
                              input logic [1:0] ra, input logic [5:0] eh, input logic eb,
                              input logic [31:0] er);
    vec_t v;
    v.dev = dv; v.we = w; v.addr = a; v.wdata = wd; v.ack = ak; v.done = dn;
    v.raddr = ra; v.e_hwint = eh; v.e_busy = eb; v.e_rdata = er;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, required %h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t e;
    bit   got;
    int   e_id;

    //          dev  we a  wdata  ak dn ra  hwint busy rdata
    tbl[0]  = mk(6'h00,1,1,32'h01,0,0,1, 6'h00,0,32'h01);
    tbl[1]  = mk(6'h00,1,2,32'h3F,0,0,2, 6'h00,0,32'h3F);
    tbl[2]  = mk(6'h01,0,0,32'h00,0,0,0, 6'h00,0,32'h01);
    tbl[3]  = mk(6'h00,0,0,32'h00,0,0,3, 6'h01,1,32'h8000_0100);
    tbl[4]  = mk(6'h00,0,0,32'h00,1,0,0, 6'h01,1,32'h00);
    tbl[5]  = mk(6'h00,0,0,32'h00,0,0,3, 6'h01,1,32'h8000_0200);
    tbl[6]  = mk(6'h00,0,0,32'h00,0,1,3, 6'h00,0,32'h00);
    tbl[7]  = mk(6'h00,1,1,32'h00,0,0,1, 6'h00,0,32'h00);
    tbl[8]  = mk(6'h24,0,0,32'h00,0,0,0, 6'h00,0,32'h24);
    tbl[9]  = mk(6'h24,0,0,32'h00,0,0,3, 6'h04,1,32'h8000_0102);
    tbl[10] = mk(6'h24,0,0,32'h00,1,0,3, 6'h04,1,32'h8000_0202);
    tbl[11] = mk(6'h20,0,0,32'h00,0,1,0, 6'h00,0,32'h20);
    tbl[12] = mk(6'h20,0,0,32'h00,0,0,3, 6'h20,1,32'h8000_0105);
    tbl[13] = mk(6'h20,0,0,32'h00,1,0,3, 6'h20,1,32'h8000_0205);
    tbl[14] = mk(6'h00,0,0,32'h00,0,1,0, 6'h00,0,32'h00);
    tbl[15] = mk(6'h08,0,0,32'h00,0,0,0, 6'h00,0,32'h08);
    tbl[16] = mk(6'h08,0,0,32'h00,0,0,3, 6'h08,1,32'h8000_0103);
    tbl[17] = mk(6'h00,0,0,32'h00,0,0,0, 6'h08,1,32'h00);
    tbl[18] = mk(6'h00,0,0,32'h00,0,0,3, 6'h00,0,32'h03);
    tbl[19] = mk(6'h08,0,0,32'h00,0,0,0, 6'h00,0,32'h08);
    tbl[20] = mk(6'h08,0,0,32'h00,0,0,3, 6'h08,1,32'h8000_0103);
    tbl[21] = mk(6'h08,1,2,32'h00,0,0,2, 6'h08,1,32'h00);
    tbl[22] = mk(6'h08,0,0,32'h00,1,0,3, 6'h08,1,32'h8000_0203);
    tbl[23] = mk(6'h00,0,0,32'h00,0,1,3, 6'h00,0,32'h03);
    tbl[24] = mk(6'h00,1,1,32'h02,0,0,1, 6'h00,0,32'h02);
    tbl[25] = mk(6'h02,1,0,32'h02,0,0,0, 6'h00,0,32'h02);
    tbl[26] = mk(6'h02,1,0,32'h02,0,0,0, 6'h00,0,32'h00);
    tbl[27] = mk(6'h10,1,0,32'h10,0,0,0, 6'h00,0,32'h10);
    tbl[28] = mk(6'h00,0,0,32'h00,0,0,0, 6'h00,0,32'h00);
    tbl[29] = mk(6'h10,1,2,32'h3F,0,0,0, 6'h00,0,32'h10);
    tbl[30] = mk(6'h10,0,0,32'h00,0,1,3, 6'h10,1,32'h8000_0104);
    tbl[31] = mk(6'h10,0,0,32'h00,0,1,3, 6'h10,1,32'h8000_0104);
    tbl[32] = mk(6'h10,0,0,32'h00,1,0,3, 6'h10,1,32'h8000_0204);
    tbl[33] = mk(6'h10,0,0,32'h00,1,0,3, 6'h10,1,32'h8000_0204);
    tbl[34] = mk(6'h00,0,0,32'h00,0,1,3, 6'h00,0,32'h04);
    tbl[35] = mk(6'h00,0,0,32'h00,0,0,0, 6'h00,0,32'h00);

    reset = 1'b1; dev_irq = '0; we = 1'b0; addr = 2'd0; wdata = '0;
    int_ack = 1'b0; int_done = 1'b0;
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    step();

    chk("reset hwint", 32'(hwint), 32'h0);
    chk("reset busy", 32'(busy), 32'h0);
    chk("reset cur_id", 32'(cur_id), 32'h0);
    for (int a = 0; a < 4; a++) begin
      addr = 2'(a);
      #1;
      chk($sformatf("reset rdata addr%0d", a), rdata, 32'h0);
    end

    for (int i = 0; i < 36; i++) begin
      dev_irq = tbl[i].dev; we = tbl[i].we; addr = tbl[i].addr; wdata = tbl[i].wdata;
      int_ack = tbl[i].ack; int_done = tbl[i].done;
      sb.push_back(tbl[i]);
      step();
      we = 1'b0; int_ack = 1'b0; int_done = 1'b0;
      e = sb.pop_front();
      addr = e.raddr;
      #1;
      chk($sformatf("row%0d hwint", i), 32'(hwint), 32'(e.e_hwint));
      chk($sformatf("row%0d busy", i), 32'(busy), 32'(e.e_busy));
      chk($sformatf("row%0d rdata", i), rdata, e.e_rdata);
    end

    // Reset asserted while a request is presented
    dev_irq = 6'h01;
    step();
    step();
    chk("prereset hwint", 32'(hwint), 32'h01);
    reset = 1'b1;
    #1;
    chk("async reset hwint", 32'(hwint), 32'h0);
    chk("async reset busy", 32'(busy), 32'h0);
    addr = 2'd0;
    #1;
    chk("async reset pend", rdata, 32'h0);
    addr = 2'd3;
    #1;
    chk("async reset status", rdata, 32'h0);
    dev_irq = '0;
    step();
    reset = 1'b0;

    // Every source held high: round order depends on the selection policy
    we = 1'b1; addr = 2'd2; wdata = 32'h3F; dev_irq = 6'h3F;
    step();
    we = 1'b0;
    for (int k = 0; k < 7; k++) begin
`ifdef INT_PRIO_ROTATE_EN
      id_q.push_back(k % 6);
`else
      id_q.push_back(0);
`endif
      got = 1'b0;
      for (int c = 0; c < 8 && !got; c++) begin
        step();
        if (busy) got = 1'b1;
      end
      e_id = id_q.pop_front();
      if (!got) begin
        n_chk++;
        $display("FAIL round%0d timeout: busy=0, required 1", k);
      end else begin
        chk($sformatf("round%0d cur_id", k), 32'(cur_id), 32'(e_id));
        chk($sformatf("round%0d hwint", k), 32'(hwint), 32'h1 << e_id);
        int_ack = 1'b1;
        step();
        int_ack = 1'b0;
        int_done = 1'b1;
        step();
        int_done = 1'b0;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
